// File: rtl/ping_pong_buffer_pkg.sv
// Shared sizes, types and helpers for the ping-pong buffer.
package ping_pong_buffer_pkg;

    localparam int BUFFER_DEPTH     = 512;
    localparam int BUFFER_ADDR_BITS = 9;
    localparam int BUFFER_DATA_BITS = 32;
    localparam int COUNT_BITS       = 10;

    typedef logic [BUFFER_ADDR_BITS-1:0] addr_t;
    typedef logic [BUFFER_DATA_BITS-1:0] data_t;
    typedef logic [COUNT_BITS-1:0]       count_t;

    typedef enum logic {
        BANK_0 = 1'b0,
        BANK_1 = 1'b1
    } bank_t;

    // Push counter stops at the bank depth so a full bank reads as exactly 512 words.
    function automatic count_t saturatingIncrement(input count_t value);
        return (value >= count_t'(BUFFER_DEPTH)) ? value : value + count_t'(1);
    endfunction

endpackage

// File: rtl/ping_pong_buffer_if.sv
// DMA-side and host-side access signals of the ping-pong buffer.
interface ping_pong_buffer_if;
    import ping_pong_buffer_pkg::*;

    logic        push;
    logic [31:0] pushAddress;
    data_t       pushData;
    logic [31:0] popAddress;
    data_t       popData;
    logic        hostWrite;
    addr_t       hostAddress;
    data_t       hostWriteData;
    data_t       hostReadData;
    logic        switch;
    logic        bankSelect;
    count_t      pushCount;
    count_t      hostValidWords;

    modport slave (
        input  push, pushAddress, pushData, popAddress,
        input  hostWrite, hostAddress, hostWriteData, switch,
        output popData, hostReadData, bankSelect, pushCount, hostValidWords
    );

    modport master (
        output push, pushAddress, pushData, popAddress,
        output hostWrite, hostAddress, hostWriteData, switch,
        input  popData, hostReadData, bankSelect, pushCount, hostValidWords
    );

endinterface

// File: rtl/ping_pong_bank.sv
// One 512x32 bank: single write port, registered read-before-write read port.
module ping_pong_bank
    import ping_pong_buffer_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  writeEnable,
    input  addr_t writeAddress,
    input  data_t writeData,
    input  addr_t readAddress,
    output data_t readData
);

    data_t memory [BUFFER_DEPTH];

    // Contents are never cleared; a write landing on a reset edge is dropped.
    always_ff @(posedge clock) begin
        if (writeEnable && !reset) begin
            memory[writeAddress] <= writeData;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readData <= '0;
        end else begin
            readData <= memory[readAddress];
        end
    end

endmodule

// File: rtl/ping_pong_buffer.sv
// Two banks whose ownership swaps between the DMA side and the host side on switch.
module ping_pong_buffer
    import ping_pong_buffer_pkg::*;
(
    input  logic clock,
    input  logic reset,
    ping_pong_buffer_if.slave bus
);

    bank_t  owner;
    bank_t  readOwner;
    count_t pushCount;
    count_t hostValidWords;
    count_t nextCount;

    addr_t  pushIndex;
    addr_t  popIndex;
    logic   unusedAddressBits;

    logic   writeEnable0, writeEnable1;
    addr_t  writeAddress0, writeAddress1;
    data_t  writeData0, writeData1;
    addr_t  readAddress0, readAddress1;
    data_t  readData0, readData1;

    assign pushIndex = bus.pushAddress[BUFFER_ADDR_BITS-1:0];
    assign popIndex  = bus.popAddress[BUFFER_ADDR_BITS-1:0];
    assign unusedAddressBits = ^{bus.pushAddress[31:BUFFER_ADDR_BITS],
                                 bus.popAddress[31:BUFFER_ADDR_BITS]};

    always_comb begin
        writeEnable0  = bus.push;
        writeAddress0 = pushIndex;
        writeData0    = bus.pushData;
        readAddress0  = popIndex;
        writeEnable1  = bus.hostWrite;
        writeAddress1 = bus.hostAddress;
        writeData1    = bus.hostWriteData;
        readAddress1  = bus.hostAddress;
        if (owner == BANK_1) begin
            writeEnable0  = bus.hostWrite;
            writeAddress0 = bus.hostAddress;
            writeData0    = bus.hostWriteData;
            readAddress0  = bus.hostAddress;
            writeEnable1  = bus.push;
            writeAddress1 = pushIndex;
            writeData1    = bus.pushData;
            readAddress1  = popIndex;
        end
    end

    ping_pong_bank bank0 (
        .clock        (clock),
        .reset        (reset),
        .writeEnable  (writeEnable0),
        .writeAddress (writeAddress0),
        .writeData    (writeData0),
        .readAddress  (readAddress0),
        .readData     (readData0)
    );

    ping_pong_bank bank1 (
        .clock        (clock),
        .reset        (reset),
        .writeEnable  (writeEnable1),
        .writeAddress (writeAddress1),
        .writeData    (writeData1),
        .readAddress  (readAddress1),
        .readData     (readData1)
    );

    // Read data was captured under the ownership in force at the sampling edge.
    assign bus.popData      = (readOwner == BANK_1) ? readData1 : readData0;
    assign bus.hostReadData = (readOwner == BANK_1) ? readData0 : readData1;

    assign nextCount = bus.push ? saturatingIncrement(pushCount) : pushCount;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner          <= BANK_0;
            readOwner      <= BANK_0;
            pushCount      <= '0;
            hostValidWords <= '0;
        end else begin
            readOwner <= owner;
            if (bus.switch) begin
                owner          <= (owner == BANK_0) ? BANK_1 : BANK_0;
                hostValidWords <= nextCount;
                pushCount      <= '0;
            end else begin
                pushCount <= nextCount;
            end
        end
    end

    assign bus.bankSelect     = owner;
    assign bus.pushCount      = pushCount;
    assign bus.hostValidWords = hostValidWords;

endmodule
